// File: rtl/dcm_sequencer_if.sv
// Control/status bundle between the DCM bring-up sequencer and the logic around it.
// The slave side is the sequencer; the master side drives the DCM status and retry request.
interface dcm_sequencer_if;
   logic       dcm_locked;
   logic       dcm_clkfx_stopped;
   logic       retry_req;
   logic       dcm_rst;
   logic       clk_en;
   logic       sys_reset_n;
   logic [2:0] state;
   logic [2:0] retry_count;
   logic [7:0] lost_count;
   logic       fail;

   modport master (
      output dcm_locked, dcm_clkfx_stopped, retry_req,
      input  dcm_rst, clk_en, sys_reset_n, state, retry_count, lost_count, fail
   );

   modport slave (
      input  dcm_locked, dcm_clkfx_stopped, retry_req,
      output dcm_rst, clk_en, sys_reset_n, state, retry_count, lost_count, fail
   );
endinterface

// File: rtl/dcm_sequencer.sv
// DCM bring-up sequencer: pulses DCM reset, waits for a stable lock, then enables the
// synthesized clock and releases downstream reset, retrying or giving up on lock failure.
module dcm_sequencer #(
   parameter int RST_CYCLES    = 4,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int SETTLE_CYCLES = 1024,
   parameter int RELEASE_DELAY = 16,
   parameter int MAX_RETRY     = 7
) (
   input  logic           clock,
   input  logic           reset_n,
   dcm_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   // One phase counter is shared by all states, so it must cover the longest interval.
   localparam int CNT_A   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
   localparam int CNT_B   = (RST_CYCLES > RELEASE_DELAY) ? RST_CYCLES : RELEASE_DELAY;
   localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SET_LAST    = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_CNT     = CNT_W'(RELEASE_DELAY);
   localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRY);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic             locked_p0, locked_p1, stopped_p0, stopped_p1;
   logic             locked_s, stopped_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       retry_q, retry_d, retry_inc;
   logic [7:0]       lost_q, lost_d;
   logic             attempt_failed;
   logic             sys_reset_n_d;
   logic             dcm_rst_q, clk_en_q, sys_reset_n_q, fail_q;

   // Stage p0 -> p1: two-flop synchronizers for the asynchronous DCM status pins
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         locked_p0  <= 1'b0;
         locked_p1  <= 1'b0;
         stopped_p0 <= 1'b0;
         stopped_p1 <= 1'b0;
      end else begin
         locked_p0  <= bus.dcm_locked;
         locked_p1  <= locked_p0;
         stopped_p0 <= bus.dcm_clkfx_stopped;
         stopped_p1 <= stopped_p0;
      end
   end

   assign locked_s  = locked_p1;
   assign stopped_s = stopped_p1;
   assign retry_inc = retry_q + 3'd1;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      retry_d        = retry_q;
      lost_d         = lost_q;
      attempt_failed = 1'b0;
      case (state_q)
         ST_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               attempt_failed = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (locked_s && !stopped_s) begin
               if (cnt_q == SET_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  retry_d = 3'd0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               attempt_failed = 1'b1;
            end
         end
         ST_RUN: begin
            if (!locked_s || stopped_s) begin
               state_d = ST_RST;
               cnt_d   = '0;
               lost_d  = sat_inc8(lost_q);
            end else if (cnt_q != REL_CNT) begin
               // Counter parks at RELEASE_DELAY and holds downstream reset released.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FAIL: begin
            if (bus.retry_req) begin
               state_d = ST_RST;
               cnt_d   = '0;
               retry_d = 3'd0;
            end
         end
         default: begin
            state_d = ST_RST;
            cnt_d   = '0;
         end
      endcase
      if (attempt_failed) begin
         retry_d = retry_inc;
         cnt_d   = '0;
         state_d = (retry_inc < RETRY_LIMIT) ? ST_RST : ST_FAIL;
      end
   end

   assign sys_reset_n_d = (state_d == ST_RUN) && (cnt_d == REL_CNT);

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RST;
         cnt_q         <= '0;
         retry_q       <= 3'd0;
         lost_q        <= 8'd0;
         dcm_rst_q     <= 1'b1;
         clk_en_q      <= 1'b0;
         sys_reset_n_q <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         lost_q        <= lost_d;
         dcm_rst_q     <= (state_d == ST_RST);
         clk_en_q      <= (state_d == ST_RUN);
         sys_reset_n_q <= sys_reset_n_d;
         fail_q        <= (state_d == ST_FAIL);
      end
   end

   assign bus.dcm_rst     = dcm_rst_q;
   assign bus.clk_en      = clk_en_q;
   assign bus.sys_reset_n = sys_reset_n_q;
   assign bus.state       = state_q;
   assign bus.retry_count = retry_q;
   assign bus.lost_count  = lost_q;
   assign bus.fail        = fail_q;

endmodule

// File: tb/tb_dcm_sequencer.sv
// Bench for dcm_sequencer: directed bring-up scenarios checked against a phase/age
// model of the sequencing rules every cycle, plus literal timing expectations.
`timescale 1ns/1ps
module tb_dcm_sequencer;

   localparam int P_RST = 4;
   localparam int P_TO  = 20;
   localparam int P_SET = 8;
   localparam int P_REL = 4;
   localparam int P_MAX = 3;

   logic clock;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   dcm_sequencer_if bus();

   dcm_sequencer #(
      .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .SETTLE_CYCLES(P_SET),
      .RELEASE_DELAY(P_REL), .MAX_RETRY(P_MAX)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model: phase 0..4 = RST, WAIT_LOCK, SETTLE, RUN, FAIL; age = cycles spent in the phase.
   int m_phase = 0, m_age = 0, m_retry = 0, m_lost = 0;
   bit l1 = 0, l2 = 0, s1 = 0, s2 = 0;

   task automatic model_fail_attempt();
      m_retry = m_retry + 1;
      m_phase = (m_retry < P_MAX) ? 0 : 4;
      m_age   = 0;
   endtask

   task automatic model_step(input bit rn, input bit lk, input bit st, input bit rq);
      bit ls, ss;
      if (!rn) begin
         m_phase = 0; m_age = 0; m_retry = 0; m_lost = 0;
         l1 = 0; l2 = 0; s1 = 0; s2 = 0;
         return;
      end
      ls = l2; ss = s2;
      l2 = l1; l1 = lk; s2 = s1; s1 = st;
      case (m_phase)
         0: if (m_age == P_RST - 1) begin m_phase = 1; m_age = 0; end else m_age++;
         1: begin
            if (ls) begin m_phase = 2; m_age = 0; end
            else if (m_age == P_TO - 1) model_fail_attempt();
            else m_age++;
         end
         2: begin
            if (!ls || ss) model_fail_attempt();
            else if (m_age == P_SET - 1) begin m_phase = 3; m_age = 0; m_retry = 0; end
            else m_age++;
         end
         3: begin
            if (!ls || ss) begin
               m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
               m_phase = 0; m_age = 0;
            end else m_age++;
         end
         default: if (rq) begin m_phase = 0; m_age = 0; m_retry = 0; end
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clock);
         model_step(reset_n, bus.dcm_locked, bus.dcm_clkfx_stopped, bus.retry_req);
         #1;
         check("cyc_state",   int'(bus.state), m_phase);
         check("cyc_dcm_rst", int'(bus.dcm_rst), int'(m_phase == 0));
         check("cyc_clk_en",  int'(bus.clk_en), int'(m_phase == 3));
         check("cyc_sys_rst_n", int'(bus.sys_reset_n), int'(m_phase == 3 && m_age >= P_REL));
         check("cyc_fail",    int'(bus.fail), int'(m_phase == 4));
         check("cyc_retry",   int'(bus.retry_count), m_retry);
         check("cyc_lost",    int'(bus.lost_count), m_lost);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit get_bit(input int which);
      case (which)
         0:       return bus.clk_en;
         1:       return bus.sys_reset_n;
         default: return bus.dcm_rst;
      endcase
   endfunction

   task automatic wait_state(input string name, input int s, input int budget);
      int n = 0;
      while (int'(bus.state) != s && n < budget) begin @(negedge clock); n++; end
      check(name, int'(bus.state), s);
   endtask

   task automatic wait_level(input string name, input int which, input bit val, input int budget);
      int n = 0;
      while (get_bit(which) != val && n < budget) begin @(negedge clock); n++; end
      check(name, int'(get_bit(which)), int'(val));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},   int'(bus.state), 0);
      check({tag, "_dcm_rst"}, int'(bus.dcm_rst), 1);
      check({tag, "_clk_en"},  int'(bus.clk_en), 0);
      check({tag, "_sys_rst"}, int'(bus.sys_reset_n), 0);
      check({tag, "_fail"},    int'(bus.fail), 0);
      check({tag, "_retry"},   int'(bus.retry_count), 0);
      check({tag, "_lost"},    int'(bus.lost_count), 0);
   endtask

   initial begin
      int  n;
      bit  saw_clk_en;
      reset_n = 1'b0;
      bus.dcm_locked = 1'b0;
      bus.dcm_clkfx_stopped = 1'b0;
      bus.retry_req = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_values("por");

      // Normal bring-up: lock arrives 5 cycles after dcm_rst falls
      reset_n = 1'b1;
      n = 0;
      while (bus.dcm_rst && n < 50) begin n++; @(negedge clock); end
      check("rst_pulse_len", n, 4);
      repeat (4) @(negedge clock);
      bus.dcm_locked = 1'b1;
      wait_state("enter_settle", 2, 20);
      n = 0;
      while (int'(bus.state) == 2 && n < 50) begin n++; @(negedge clock); end
      check("settle_len", n, 8);
      check("run_entered", int'(bus.state), 3);
      check("clk_en_first_run", int'(bus.clk_en), 1);
      check("sys_low_first_run", int'(bus.sys_reset_n), 0);
      n = 0;
      while (!bus.sys_reset_n && n < 50) begin @(negedge clock); n++; end
      check("release_delay", n, 4);
      check("run_retry_zero", int'(bus.retry_count), 0);

      // Lock loss in RUN
      bus.dcm_locked = 1'b0;
      wait_level("loss_clk_en_low", 0, 1'b0, 10);
      check("loss_sys_low", int'(bus.sys_reset_n), 0);
      check("loss_lost1", int'(bus.lost_count), 1);
      check("loss_state_rst", int'(bus.state), 0);
      bus.dcm_locked = 1'b1;
      wait_state("relock_run", 3, 60);
      check("relock_retry0", int'(bus.retry_count), 0);
      wait_level("relock_sys_high", 1, 1'b1, 20);

      // CLKFX stopped in RUN while still locked
      bus.dcm_clkfx_stopped = 1'b1;
      wait_level("stop_clk_en_low", 0, 1'b0, 10);
      check("stop_sys_low", int'(bus.sys_reset_n), 0);
      check("stop_lost2", int'(bus.lost_count), 2);
      check("stop_state_rst", int'(bus.state), 0);
      bus.dcm_clkfx_stopped = 1'b0;
      wait_state("stop_rerun", 3, 60);

      // Loss inside the release window: sys_reset_n must never rise
      bus.dcm_locked = 1'b0;
      n = 0;
      while (bus.clk_en && n < 10) begin
         check("window_sys_low", int'(bus.sys_reset_n), 0);
         @(negedge clock); n++;
      end
      check("window_lost3", int'(bus.lost_count), 3);
      bus.dcm_locked = 1'b1;
      wait_state("window_rerun", 3, 60);
      wait_level("window_sys_high", 1, 1'b1, 20);

      // Asynchronous reset mid-cycle in RUN
      #3 reset_n = 1'b0;
      #1 check_reset_values("async");
      @(negedge clock);
      bus.dcm_locked = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;

      // Lock drops on the 5th SETTLE cycle
      bus.dcm_locked = 1'b1;
      wait_state("drop_settle", 2, 30);
      n = 1;
      repeat (2) begin @(negedge clock); n++; end
      bus.dcm_locked = 1'b0;
      saw_clk_en = 1'b0;
      while (int'(bus.state) == 2 && n < 50) begin
         @(negedge clock);
         if (bus.clk_en) saw_clk_en = 1'b1;
         if (int'(bus.state) == 2) n++;
      end
      check("drop_settle_cycles", n, 5);
      check("drop_retry1", int'(bus.retry_count), 1);
      check("drop_state_rst", int'(bus.state), 0);
      check("drop_no_clk_en", int'(saw_clk_en), 0);

      // Lock never arrives: three timed-out attempts, then FAIL
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         wait_state("timeout_wait", 1, 30);
         n = 0;
         while (int'(bus.state) == 1 && n < 100) begin n++; @(negedge clock); end
         check("timeout_len", n, 20);
         check("timeout_retry", int'(bus.retry_count), a);
         check("timeout_next", int'(bus.state), (a < 3) ? 0 : 4);
         if (a == 1) begin
            bus.retry_req = 1'b1;
            @(negedge clock);
            bus.retry_req = 1'b0;
         end
      end
      check("fail_flag", int'(bus.fail), 1);
      repeat (5) @(negedge clock);
      check("fail_hold", int'(bus.state), 4);
      bus.retry_req = 1'b1;
      @(negedge clock);
      bus.retry_req = 1'b0;
      check("retry_state", int'(bus.state), 0);
      check("retry_count0", int'(bus.retry_count), 0);
      check("retry_fail0", int'(bus.fail), 0);
      check("retry_dcm_rst", int'(bus.dcm_rst), 1);

      // Lost-count saturation after many RUN losses
      bus.dcm_locked = 1'b1;
      for (int i = 0; i < 258; i++) begin
         wait_state("sat_run", 3, 60);
         bus.dcm_locked = 1'b0;
         wait_state("sat_rst", 0, 10);
         bus.dcm_locked = 1'b1;
      end
      check("lost_saturated", int'(bus.lost_count), 255);

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
